ifetch_ctrl: RTL and testbench
==============================

# ifetch_ctrl

Instruction-fetch controller for the pipelined core. It owns the architectural fetch PC and drives the instruction bus request/response handshake. It captures each returned instruction into an output buffer that feeds the fetch/decode stage. It absorbs back-pressure from decode (stall) and control-flow redirects, including redirects that arrive while a bus transaction is outstanding.

## Interface
- RESET_PC, 64'h8000_0000, fetch PC after reset
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- ireq  out  ibus_req_t  instruction bus request; fields used: valid (1), addr (64)
- iresp  in  ibus_resp_t  instruction bus response; fields used: addr_ok (1), data_ok (1), data (32)
- redirect_valid  in  1  control-flow redirect this cycle
- redirect_pc  in  64  redirect target; bits [1:0] ignored (treated as 00)
- stall  in  1  decode cannot accept the buffered instruction this cycle
- out_valid  out  1  out_pc/out_instr hold a valid fetched instruction
- out_pc  out  64  PC of buffered instruction
- out_instr  out  32  buffered instruction word

## Operation
- Registers: pc (64), state, discard (1), out buffer {out_valid, out_pc, out_instr}.
- FSM states:
  - REQ: ireq.valid=1, ireq.addr=pc. On addr_ok && data_ok in the same cycle, go to HOLD. On addr_ok alone, go to WAIT. Otherwise stay in REQ.
  - WAIT: ireq.valid=0, waiting for data_ok. On data_ok, go to HOLD, or go to REQ if discard is set.
  - HOLD: out_valid=1. When consumed (!stall) or redirected, pc advances and state goes to REQ.
- Capture: on an accepted, non-discarded data_ok, load out_instr<=iresp.data and out_pc<=pc; out_valid rises the next cycle.
- Consume: in HOLD with !stall && !redirect_valid, set pc<=pc+4, out_valid<=0, state<=REQ.
- Redirect in HOLD: pc<=redirect_pc&~3, out_valid<=0, state<=REQ. Redirect wins over consumption in the same cycle.
- Redirect in REQ before addr_ok: ireq.addr must stay stable while valid && !addr_ok, so the target is latched as pending_pc and pending=1. When addr_ok arrives, set discard=1 and let the transaction complete (WAIT or same-cycle data_ok). The returned data is then dropped and pc<=pending_pc.
- Redirect in REQ coinciding with addr_ok: same as above. The transaction is launched and then discarded.
- Redirect in WAIT: discard<=1, pc_target<=redirect_pc. On data_ok, drop the data, pc<=target, state<=REQ, discard<=0.
- Multiple redirects before the discard completes: the latest redirect_pc wins.
- A discarded response never reaches the out buffer and never raises out_valid.
- Width rules: pc+4 wraps modulo 2^64. iresp.data is taken unchanged as 32 bits.

## Timing
- Reset values: pc=RESET_PC, state=REQ, discard=0, pending=0, out_valid=0, out_pc=0, out_instr=0.
- ireq.valid is 1 in the first cycle after reset is released, with ireq.addr=RESET_PC.
- Reset asserted mid-transaction: all state returns to reset values next cycle. Any late data_ok is ignored because the FSM is in REQ and discard=0, and data_ok in REQ without a launch is not legal bus behaviour.
- Best-case latency: a request accepted with addr_ok && data_ok in cycle N gives out_valid=1 in cycle N+1. The next request goes out in N+2 if decode does not stall in N+1.
- Single-transaction-outstanding controller: at most one ibus transaction in flight.
- ireq.valid and ireq.addr are combinational from registered state only, with no dependence on iresp in the same cycle.
- stall is sampled only in HOLD. It has no effect in REQ or WAIT.

## Test plan
- Reset and straight-line fetch: release reset with a zero-wait bus (addr_ok=data_ok=1) returning 0x00000013 -> ireq.addr goes 0x8000_0000, 0x8000_0004, 0x8000_0008; out_valid pulses once per instruction with matching out_pc.
- Slow bus: addr_ok held low 2 cycles, data_ok 3 cycles after addr_ok, data 0x00100093 -> ireq.addr stable throughout; out_valid=1 exactly one cycle after data_ok with out_instr=0x00100093 and out_pc=0x8000_0000.
- Stall: out_valid=1 with stall=1 for 4 cycles -> out_pc/out_instr unchanged, no new ireq.valid; stall drops -> the next request is to out_pc+4.
- Redirect in WAIT: redirect_valid=1 with redirect_pc=0x8000_0100 while waiting; data_ok then returns 0xDEADBEEF -> out_valid stays 0; the next ireq.addr=0x8000_0100.
- Redirect in REQ before addr_ok, redirect_pc=0x8000_0203 -> ireq.addr unchanged until addr_ok; the response is dropped; the next ireq.addr=0x8000_0200.
- Redirect and consume together in HOLD (stall=0, redirect_pc=0x8000_0040) -> the next ireq.addr=0x8000_0040, not pc+4; out_valid=0.

Source files
------------

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction-fetch controller.
//
// Owns the architectural fetch PC and drives a single-outstanding
// instruction bus transaction. Each returned instruction is captured into an
// output buffer that feeds decode. Decode back-pressure (stall) and
// control-flow redirects are absorbed here. A redirect that lands while a
// bus transaction is in flight lets that transaction finish, drops its data,
// and then restarts fetch at the redirect target.
//
// Bus handshake:
//   ireq.valid / ireq.addr are driven from registered state only. While
//   ireq.valid is high and iresp.addr_ok is low, ireq.addr holds steady.
//   addr_ok accepts the address. data_ok returns the data, either in the
//   same cycle as addr_ok or in a later cycle. Only one transaction is ever
//   in flight.
//   The out buffer is valid while out_valid is high. Decode consumes it in
//   any cycle where stall is low.
//
// Ports:
//   clk, reset         clock; synchronous active-high reset
//   ireq               bus request {valid, addr[63:0]}
//   iresp              bus response {addr_ok, data_ok, data[31:0]}
//   redirect_valid/pc  control-flow redirect; pc[1:0] treated as 00
//   stall              decode cannot take the buffered instruction
//   out_valid/pc/instr buffered fetched instruction
//   dbg_state          current FSM state (0=REQ, 1=WAIT, 2=HOLD)

package ifetch_pkg;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;
endpackage

module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output ibus_req_t   ireq,
  input  ibus_resp_t  iresp,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        stall,
  output logic        out_valid,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] tgt_q, tgt_d;      // redirect target awaiting a drop
  logic        pending_q, pending_d;  // redirect seen in REQ before addr_ok
  logic        discard_q, discard_d;  // in-flight response must be dropped
  logic        ov_q, ov_d;
  logic [63:0] opc_q, opc_d;
  logic [31:0] oi_q, oi_d;
  logic [63:0] redir_pc;
  logic        drop;

  assign redir_pc = redirect_pc & ~64'h3;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      tgt_q     <= 64'd0;
      pending_q <= 1'b0;
      discard_q <= 1'b0;
      ov_q      <= 1'b0;
      opc_q     <= 64'd0;
      oi_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      tgt_q     <= tgt_d;
      pending_q <= pending_d;
      discard_q <= discard_d;
      ov_q      <= ov_d;
      opc_q     <= opc_d;
      oi_q      <= oi_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    tgt_d     = tgt_q;
    pending_d = pending_q;
    discard_d = discard_q;
    ov_d      = ov_q;
    opc_d     = opc_q;
    oi_d      = oi_q;
    drop      = 1'b0;

    case (state_q)
      S_REQ: begin
        // The address is already on the bus, so a redirect here is only
        // remembered. The request itself must not change until accepted.
        if (redirect_valid) begin
          tgt_d     = redir_pc;
          pending_d = 1'b1;
        end
        if (iresp.addr_ok) begin
          drop = pending_q || redirect_valid;
          if (iresp.data_ok) begin
            if (drop) begin
              pc_d      = tgt_d;
              pending_d = 1'b0;
            end else begin
              ov_d    = 1'b1;
              opc_d   = pc_q;
              oi_d    = iresp.data;
              state_d = S_HOLD;
            end
          end else begin
            discard_d = drop;
            pending_d = 1'b0;
            state_d   = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        // Latest redirect wins. A redirect coinciding with data_ok still
        // drops that data.
        if (redirect_valid) begin
          tgt_d     = redir_pc;
          discard_d = 1'b1;
        end
        if (iresp.data_ok) begin
          if (discard_d) begin
            pc_d      = tgt_d;
            discard_d = 1'b0;
            state_d   = S_REQ;
          end else begin
            ov_d    = 1'b1;
            opc_d   = pc_q;
            oi_d    = iresp.data;
            state_d = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (redirect_valid) begin
          pc_d    = redir_pc;
          ov_d    = 1'b0;
          state_d = S_REQ;
        end else if (!stall) begin
          pc_d    = pc_q + 64'd4;
          ov_d    = 1'b0;
          state_d = S_REQ;
        end
      end

      default: state_d = S_REQ;
    endcase
  end

  always_comb begin
    ireq       = '0;
    ireq.valid = (state_q == S_REQ);
    ireq.addr  = pc_q;
  end

  assign out_valid = ov_q;
  assign out_pc    = opc_q;
  assign out_instr = oi_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: a table of per-cycle input/expected-output
// records, followed by a hand-written zero-wait straight-line sequence.

module tb_ifetch_ctrl;
  import ifetch_pkg::*;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clk;
  logic        reset;
  ibus_req_t   ireq;
  ibus_resp_t  iresp;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        stall;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  ifetch_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .ireq           (ireq),
    .iresp          (iresp),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        aok;
    logic        dok;
    logic [31:0] data;
    logic        rv;
    logic [63:0] rpc;
    logic        stl;
    logic        e_iv;
    logic [63:0] e_addr;
    logic        e_ov;
    logic [63:0] e_opc;
    logic [31:0] e_oi;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic aok, input logic dok,
                     input logic [31:0] data, input logic rv,
                     input logic [63:0] rpc, input logic stl,
                     input logic e_iv, input logic [63:0] e_addr,
                     input logic e_ov, input logic [63:0] e_opc,
                     input logic [31:0] e_oi);
    vec_t v;
    v.rst = rst; v.aok = aok; v.dok = dok; v.data = data; v.rv = rv;
    v.rpc = rpc; v.stl = stl; v.e_iv = e_iv; v.e_addr = e_addr;
    v.e_ov = e_ov; v.e_opc = e_opc; v.e_oi = e_oi;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // driver: apply inputs at the falling edge
  task automatic drive(input logic rst, input logic aok, input logic dok,
                       input logic [31:0] data, input logic rv,
                       input logic [63:0] rpc, input logic stl);
    reset          = rst;
    iresp.addr_ok  = aok;
    iresp.data_ok  = dok;
    iresp.data     = data;
    redirect_valid = rv;
    redirect_pc    = rpc;
    stall          = stl;
  endtask

  localparam logic [63:0] X64 = 64'd0;

  initial begin
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, X64, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Straight-line zero-wait fetch after reset.
    add(0,1,1,32'h0000_0013,0,X64,0, 1,64'h8000_0000, 0,64'h0,32'h0);
    add(0,0,0,32'h0,0,X64,0,         0,64'h8000_0000, 1,64'h8000_0000,32'h13);
    add(0,1,1,32'h0000_0013,0,X64,0, 1,64'h8000_0004, 0,64'h8000_0000,32'h13);
    add(0,0,0,32'h0,0,X64,0,         0,64'h8000_0004, 1,64'h8000_0004,32'h13);
    add(0,0,0,32'h0,0,X64,0,         1,64'h8000_0008, 0,64'h8000_0004,32'h13);
    // Reset, then slow bus: addr_ok low 2 cycles, data_ok 3 cycles later.
    add(1,0,0,32'h0,0,X64,0,         1,64'h8000_0008, 0,64'h8000_0004,32'h13);
    add(0,0,0,32'h0,0,X64,0,         1,64'h8000_0000, 0,64'h0,32'h0);
    add(0,0,0,32'h0,0,X64,0,         1,64'h8000_0000, 0,64'h0,32'h0);
    add(0,1,0,32'h0,0,X64,0,         1,64'h8000_0000, 0,64'h0,32'h0);
    add(0,0,0,32'h0,0,X64,0,         0,64'h8000_0000, 0,64'h0,32'h0);
    add(0,0,0,32'h0,0,X64,0,         0,64'h8000_0000, 0,64'h0,32'h0);
    add(0,0,1,32'h0010_0093,0,X64,0, 0,64'h8000_0000, 0,64'h0,32'h0);
    // Stall 4 cycles in HOLD (bus strobes must be ignored), then release.
    for (int i = 0; i < 4; i++)
      add(0,1,1,32'hFFFF_FFFF,0,X64,1, 0,64'h8000_0000, 1,64'h8000_0000,32'h0010_0093);
    add(0,0,0,32'h0,0,X64,0,         0,64'h8000_0000, 1,64'h8000_0000,32'h0010_0093);
    add(0,0,0,32'h0,0,X64,0,         1,64'h8000_0004, 0,64'h8000_0000,32'h0010_0093);
    // Redirect in WAIT.
    add(0,1,0,32'h0,0,X64,0,         1,64'h8000_0004, 0,64'h8000_0000,32'h0010_0093);
    add(0,0,0,32'h0,1,64'h8000_0100,0, 0,64'h8000_0004, 0,64'h8000_0000,32'h0010_0093);
    add(0,0,1,32'hDEAD_BEEF,0,X64,0, 0,64'h8000_0004, 0,64'h8000_0000,32'h0010_0093);
    add(0,0,0,32'h0,0,X64,0,         1,64'h8000_0100, 0,64'h8000_0000,32'h0010_0093);
    // Redirect in REQ before addr_ok, unaligned target.
    add(0,0,0,32'h0,1,64'h8000_0203,0, 1,64'h8000_0100, 0,64'h8000_0000,32'h0010_0093);
    add(0,0,0,32'h0,0,X64,0,         1,64'h8000_0100, 0,64'h8000_0000,32'h0010_0093);
    add(0,1,0,32'h0,0,X64,0,         1,64'h8000_0100, 0,64'h8000_0000,32'h0010_0093);
    add(0,0,1,32'h1234_5678,0,X64,0, 0,64'h8000_0100, 0,64'h8000_0000,32'h0010_0093);
    add(0,0,0,32'h0,0,X64,0,         1,64'h8000_0200, 0,64'h8000_0000,32'h0010_0093);
    // Redirect and consume together in HOLD.
    add(0,1,1,32'h0000_0513,0,X64,0, 1,64'h8000_0200, 0,64'h8000_0000,32'h0010_0093);
    add(0,0,0,32'h0,1,64'h8000_0040,0, 0,64'h8000_0200, 1,64'h8000_0200,32'h0000_0513);
    add(0,0,0,32'h0,0,X64,0,         1,64'h8000_0040, 0,64'h8000_0200,32'h0000_0513);
    // Redirect coinciding with addr_ok+data_ok in REQ.
    add(0,1,1,32'hAAAA_AAAA,1,64'h8000_0080,0, 1,64'h8000_0040, 0,64'h8000_0200,32'h0000_0513);
    add(0,0,0,32'h0,0,X64,0,         1,64'h8000_0080, 0,64'h8000_0200,32'h0000_0513);
    // Two redirects in WAIT: the later one wins.
    add(0,1,0,32'h0,0,X64,0,         1,64'h8000_0080, 0,64'h8000_0200,32'h0000_0513);
    add(0,0,0,32'h0,1,64'h8000_0300,0, 0,64'h8000_0080, 0,64'h8000_0200,32'h0000_0513);
    add(0,0,0,32'h0,1,64'h8000_0404,0, 0,64'h8000_0080, 0,64'h8000_0200,32'h0000_0513);
    add(0,0,1,32'hBBBB_BBBB,0,X64,0, 0,64'h8000_0080, 0,64'h8000_0200,32'h0000_0513);
    add(0,0,0,32'h0,0,X64,0,         1,64'h8000_0404, 0,64'h8000_0200,32'h0000_0513);
    // Reset mid-transaction, then a late data_ok that must be ignored.
    add(0,1,0,32'h0,0,X64,0,         1,64'h8000_0404, 0,64'h8000_0200,32'h0000_0513);
    add(1,0,0,32'h0,0,X64,0,         0,64'h8000_0404, 0,64'h8000_0200,32'h0000_0513);
    add(0,0,1,32'hCCCC_CCCC,0,X64,0, 1,64'h8000_0000, 0,64'h0,32'h0);
    add(0,0,0,32'h0,0,X64,0,         1,64'h8000_0000, 0,64'h0,32'h0);
    // PC wrap at the top of the address space.
    add(0,1,1,32'h1111_1111,0,X64,0, 1,64'h8000_0000, 0,64'h0,32'h0);
    add(0,0,0,32'h0,1,64'hFFFF_FFFF_FFFF_FFFE,0, 0,64'h8000_0000, 1,64'h8000_0000,32'h1111_1111);
    add(0,1,1,32'h2222_2222,0,X64,0, 1,64'hFFFF_FFFF_FFFF_FFFC, 0,64'h8000_0000,32'h1111_1111);
    add(0,0,0,32'h0,0,X64,0,         0,64'hFFFF_FFFF_FFFF_FFFC, 1,64'hFFFF_FFFF_FFFF_FFFC,32'h2222_2222);
    add(0,0,0,32'h0,0,X64,0,         1,64'h0, 0,64'hFFFF_FFFF_FFFF_FFFC,32'h2222_2222);

    // Apply table: outputs depend only on registered state, so they are
    // checked at the falling edge, before the next rising edge consumes the
    // inputs.
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].aok, vecs[i].dok, vecs[i].data,
            vecs[i].rv, vecs[i].rpc, vecs[i].stl);
      chk("ireq_valid", i, 64'(ireq.valid), 64'(vecs[i].e_iv));
      chk("ireq_addr",  i, ireq.addr,        vecs[i].e_addr);
      chk("out_valid",  i, 64'(out_valid),   64'(vecs[i].e_ov));
      chk("out_pc",     i, out_pc,           vecs[i].e_opc);
      chk("out_instr",  i, 64'(out_instr),   64'(vecs[i].e_oi));
      @(negedge clk);
    end

    // Hand-written: reset then a bus that always answers immediately.
    // Expect REQ/HOLD alternation with the address stepping by 4.
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, X64, 1'b0);
    @(negedge clk);
    begin
      int fetched = 0;
      logic [63:0] exp_addr = RST_PC;
      logic [63:0] last_addr = 64'd0;
      for (int k = 0; k < 6; k++) begin
        drive(1'b0, 1'b1, 1'b1, 32'h0000_0013, 1'b0, X64, 1'b0);
        if (k % 2 == 0) begin
          chk("zw_ireq_valid", 1000 + k, 64'(ireq.valid), 64'd1);
          chk("zw_ireq_addr",  1000 + k, ireq.addr, exp_addr);
          chk("zw_out_valid",  1000 + k, 64'(out_valid), 64'd0);
          last_addr = exp_addr;
          exp_addr  = exp_addr + 64'd4;
        end else begin
          chk("zw_ireq_valid", 1000 + k, 64'(ireq.valid), 64'd0);
          chk("zw_out_valid",  1000 + k, 64'(out_valid), 64'd1);
          chk("zw_out_pc",     1000 + k, out_pc, last_addr);
          chk("zw_out_instr",  1000 + k, 64'(out_instr), 64'h13);
          if (out_valid) fetched++;
        end
        @(negedge clk);
      end
      chk("zw_fetch_count", 2000, 64'(fetched), 64'd3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Whole-run time limit.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
